// File: rtl/mult_ctrl_pkg.sv
// Shared state encodings and default widths for the shared-multiplier controller.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam int DEF_M = 3;
    localparam int DEF_N = 2;
    localparam int DEF_R = 4;

endpackage

// File: rtl/multiplier.sv
// Unsigned M x N multiplier with an exact M+N bit product; purely combinational.
// No handshake: the caller registers operands and result around it.
module multiplier #(
    parameter int M = 3,
    parameter int N = 2
) (
    input  logic [M-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [M+N-1:0] p_o
);

    assign p_o = (M+N)'(a_i) * (M+N)'(b_i);

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter sharing one multiplier among R requesters; grant to rsp_valid is 2 cycles.
// One operation in flight; rsp_ready low holds RESP and suppresses all grants.
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int M    = DEF_M,
    parameter int N    = DEF_N,
    parameter int R    = DEF_R,
    parameter int ID_W = $clog2(R)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [R-1:0]      req_valid,
    input  logic [R*M-1:0]    req_a,
    input  logic [R*N-1:0]    req_b,
    output logic [R-1:0]      req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [M+N-1:0]    rsp_p,
    output logic [ID_W-1:0]   rsp_id
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [M-1:0]      op_a_q, op_a_d;
    logic [N-1:0]      op_b_q, op_b_d;
    logic [M+N-1:0]    rsp_p_q, rsp_p_d;
    logic [M+N-1:0]    mult_p;
    logic [ID_W:0]     pick;
    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;

    // Returns {found, index} of the first valid requester at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [R-1:0] vld, input logic [ID_W-1:0] ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx_w;
        int              idx;
        res = '0;
        for (int k = R - 1; k >= 0; k--) begin
            idx   = (int'(ptr) + k) % R;
            idx_w = ID_W'(idx);
            if (vld[idx_w]) res = {1'b1, idx_w};
        end
        return res;
    endfunction

    assign pick     = rr_pick(req_valid, rr_ptr_q);
    assign pick_vld = pick[ID_W];
    assign pick_id  = pick[ID_W-1:0];

    multiplier #(
        .M (M),
        .N (N)
    ) u_mult (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (mult_p)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_id_d  = cur_id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rsp_p_d   = rsp_p_q;
        rsp_id_d  = rsp_id_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    req_ready[pick_id] = 1'b1;
                    op_a_d   = req_a[int'(pick_id)*M +: M];
                    op_b_d   = req_b[int'(pick_id)*N +: N];
                    cur_id_d = pick_id;
                    rr_ptr_d = (int'(pick_id) == R - 1) ? '0 : pick_id + ID_W'(1);
                    state_d  = MUL;
                end
            end
            MUL: begin
                rsp_p_d  = mult_p;
                rsp_id_d = cur_id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset is asynchronous, so the combinational grant must drop with it too.
        if (!rst_n) req_ready = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cur_id_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            rsp_p_q  <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_id_q <= cur_id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rsp_p_q  <= rsp_p_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_mult_share_ctrl;

    localparam int M    = 3;
    localparam int N    = 2;
    localparam int R    = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [R-1:0]      req_valid = '0;
    logic [R*M-1:0]    req_a = '0;
    logic [R*N-1:0]    req_b = '0;
    logic [R-1:0]      req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [M+N-1:0]    rsp_p;
    logic [ID_W-1:0]   rsp_id;

    always #5 clk = ~clk;

    mult_share_ctrl #(
        .M    (M),
        .N    (N),
        .R    (R),
        .ID_W (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: a single outstanding transaction with its grant cycle; response is due 2 cycles later.
    int m_ptr  = 0;
    bit m_busy = 1'b0;
    int m_gcyc = 0;
    int m_p    = 0;
    int m_id   = 0;
    int cyc    = 0;
    bit sticky = 1'b0;

    int g_log[$];
    int g_cyc[$];
    int p_log[$];
    int id_log[$];

    function automatic int m_pick(input logic [R-1:0] v);
        for (int k = 0; k < R; k++) begin
            if (v[(m_ptr + k) % R]) return (m_ptr + k) % R;
        end
        return -1;
    endfunction

    function automatic int field_a(input int i);
        return int'(req_a >> (i * M)) & ((1 << M) - 1);
    endfunction

    function automatic int field_b(input int i);
        return int'(req_b >> (i * N)) & ((1 << N) - 1);
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        g_log.delete();
        g_cyc.delete();
        p_log.delete();
        id_log.delete();
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]       = 1'b1;
        req_a[i*M +: M]    = M'(a);
        req_b[i*N +: N]    = N'(b);
    endtask

    task automatic cycle();
        int           g;
        int           og;
        bit           in_rsp;
        logic [R-1:0] exp_rdy;
        @(negedge clk);
        g       = -1;
        exp_rdy = '0;
        in_rsp  = m_busy && (cyc >= m_gcyc + 2);
        if (!m_busy) begin
            g = m_pick(req_valid);
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk_eq("rsp_valid", 32'(rsp_valid), 32'(in_rsp));
        if (in_rsp) begin
            chk_eq("rsp_p", 32'(rsp_p), m_p);
            chk_eq("rsp_id", 32'(rsp_id), m_id);
        end
        og = -1;
        for (int i = 0; i < R; i++) if (req_ready[i] && req_valid[i]) og = i;
        if (og >= 0) begin
            g_log.push_back(og);
            g_cyc.push_back(cyc);
        end
        if (in_rsp && rsp_ready) begin
            p_log.push_back(int'(rsp_p));
            id_log.push_back(int'(rsp_id));
        end
        @(posedge clk);
        if (in_rsp && rsp_ready) begin
            m_busy = 1'b0;
        end else if (g >= 0) begin
            m_busy = 1'b1;
            m_gcyc = cyc;
            m_id   = g;
            m_p    = field_a(g) * field_b(g);
            m_ptr  = (g + 1) % R;
        end
        #1;
        if (og >= 0 && !sticky) req_valid[og] = 1'b0;
        cyc++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_eq("rst_req_ready", 32'(req_ready), 0);
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        chk_eq("rst_rsp_p", 32'(rsp_p), 0);
        chk_eq("rst_rsp_id", 32'(rsp_id), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_busy = 1'b0;
    endtask

    initial begin
        // Reset with every port requesting: no grant may leak out while reset is low.
        req_valid = '1;
        do_reset();
        req_valid = '0;

        // Single request on port 2.
        clear_logs();
        rsp_ready = 1'b1;
        set_req(2, 5, 3);
        cycles(5);
        chk_eq("single_ngrants", 32'(g_log.size()), 1);
        chk_eq("single_gid", 32'(qget(g_log, 0)), 2);
        chk_eq("single_p", 32'(qget(p_log, 0)), 15);
        chk_eq("single_id", 32'(qget(id_log, 0)), 2);

        // All four ports at once from a fresh pointer.
        do_reset();
        clear_logs();
        set_req(0, 1, 1);
        set_req(1, 2, 2);
        set_req(2, 3, 3);
        set_req(3, 7, 3);
        cycles(13);
        for (int i = 0; i < 4; i++) chk_eq("all_gid", 32'(qget(g_log, i)), i);
        for (int i = 1; i < 4; i++) chk_eq("all_gap", 32'(qget(g_cyc, i) - qget(g_cyc, i - 1)), 3);
        chk_eq("all_p0", 32'(qget(p_log, 0)), 1);
        chk_eq("all_p1", 32'(qget(p_log, 1)), 4);
        chk_eq("all_p2", 32'(qget(p_log, 2)), 9);
        chk_eq("all_p3", 32'(qget(p_log, 3)), 21);
        clear_logs();
        set_req(3, 1, 1);
        set_req(0, 1, 2);
        cycles(8);
        chk_eq("wrap_first", 32'(qget(g_log, 0)), 0);

        // Backpressure: port 1 response held 5 cycles while port 2 waits.
        clear_logs();
        rsp_ready = 1'b0;
        set_req(1, 6, 2);
        cycle();
        set_req(2, 3, 2);
        cycles(6);
        rsp_ready = 1'b1;
        cycles(6);
        chk_eq("bp_g0", 32'(qget(g_log, 0)), 1);
        chk_eq("bp_g1", 32'(qget(g_log, 1)), 2);
        chk_eq("bp_gap", 32'(qget(g_cyc, 1) - qget(g_cyc, 0)), 8);
        chk_eq("bp_p0", 32'(qget(p_log, 0)), 12);
        chk_eq("bp_p1", 32'(qget(p_log, 1)), 6);

        // Fairness: ports 0 and 3 permanently valid, pointer now at 3.
        clear_logs();
        sticky = 1'b1;
        set_req(0, 2, 2);
        set_req(3, 3, 1);
        cycles(12);
        sticky    = 1'b0;
        req_valid = '0;
        cycles(3);
        chk_eq("fair_n", 32'(g_log.size()), 4);
        for (int i = 0; i < 4; i++) chk_eq("fair_gid", 32'(qget(g_log, i)), (i % 2 == 0) ? 3 : 0);

        // Boundary operands, exercising the top product bit.
        clear_logs();
        set_req(1, 0, 3);
        set_req(2, 7, 0);
        set_req(3, 7, 3);
        cycles(10);
        chk_eq("bnd_p0", 32'(qget(p_log, 0)), 0);
        chk_eq("bnd_p1", 32'(qget(p_log, 1)), 0);
        chk_eq("bnd_p2", 32'(qget(p_log, 2)), 21);
        chk_eq("bnd_id2", 32'(qget(id_log, 2)), 3);

        // Reset while the operation is in MUL; port 0 must win afterwards.
        set_req(1, 5, 3);
        cycle();
        set_req(0, 2, 3);
        set_req(1, 1, 1);
        set_req(2, 1, 2);
        set_req(3, 1, 3);
        clear_logs();
        do_reset();
        cycles(4);
        chk_eq("rst_first_g", 32'(qget(g_log, 0)), 0);
        chk_eq("rst_first_p", 32'(qget(p_log, 0)), 6);
        chk_eq("rst_first_id", 32'(qget(id_log, 0)), 0);
        req_valid = '0;
        cycles(4);

        // Random traffic with random consumer stalls.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < R; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Round-robin controller that shares one `multiplier` datapath instance among R requesters. Each requester presents an unsigned M-bit × N-bit operand pair with a valid/ready handshake. The controller grants one requester, registers its operands and drives the multiplier from those registers. It registers the (M+N)-bit product and returns it on a single response channel tagged with the requester index. It sits between client blocks and the shared multiplier.

## Interface
Parameters:
- `M`, default 3: width of operand A.
- `N`, default 2: width of operand B.
- `R`, default 4: number of requesters, R ≥ 2.
- `ID_W`, default $clog2(R): width of the requester index.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req_valid`, input, R: per-requester request valid.
- `req_a`, input, R*M: operand A; requester i occupies bits [i*M +: M].
- `req_b`, input, R*N: operand B; requester i occupies bits [i*N +: N].
- `req_ready`, output, R: one-hot grant; handshake completes on `req_valid[i] & req_ready[i]`.
- `rsp_valid`, output, 1: product available.
- `rsp_ready`, input, 1: consumer accepts the product.
- `rsp_p`, output, M+N: product A*B, unsigned.
- `rsp_id`, output, ID_W: index of the requester that owns `rsp_p`.

## Operation
- FSM states: IDLE → MUL → RESP → IDLE.
- IDLE:
  - Pick the first asserted `req_valid[i]` searching from pointer `rr_ptr` upward, wrapping R-1 → 0.
  - Assert `req_ready[i]` combinationally for that index only.
  - On the handshake, capture `req_a`/`req_b` slice i into `op_a`/`op_b` and capture i into `cur_id`.
  - Set `rr_ptr` = (i+1) mod R, then go to MUL.
  - With no valid request, stay in IDLE; `rr_ptr` holds.
- MUL: the multiplier sees `op_a`/`op_b`. Register its output into `rsp_p` and register `cur_id` into `rsp_id`. Go to RESP.
- RESP:
  - `rsp_valid`=1.
  - `rsp_p` and `rsp_id` are held stable until `rsp_valid & rsp_ready`, then go to IDLE.
- `req_ready` is all-zero in MUL and RESP. Only one operation is in flight at a time.
- Requesters hold `req_valid` and their operands stable until granted. Dropping `req_valid` before the grant is legal: that requester is simply not granted.
- Width rule: the product is always exact in M+N bits. There is no overflow and no truncation.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n`=0):
  - state=IDLE, `rr_ptr`=0, `op_a`=`op_b`=0.
  - `rsp_valid`=0, `rsp_p`=0, `rsp_id`=0, `req_ready`=0.
- Reset mid-operation discards the in-flight operation. No response is produced for it.
- Latency: handshake in cycle T → `rsp_valid` rises in cycle T+2.
- Minimum initiation interval is 3 cycles. When `rsp_ready` is held high, the next grant is possible in cycle T+3.
- Backpressure: while `rsp_ready`=0, RESP holds indefinitely. `rsp_*` stays constant and no grants are issued.
- Simultaneous requests: exactly one grant per IDLE cycle, in strict round-robin order from `rr_ptr`.
- Pointer wrap: a grant to R-1 sets `rr_ptr`=0.

## Structure
- Shared package `mult_ctrl_pkg` holds:
  - state encodings IDLE=2'b00, MUL=2'b01, RESP=2'b10;
  - the default M/N/R constants.
- One sub-module: the existing `multiplier` (instance `u_mult`, parameters M and N passed through). It is fed only from registers.
- The round-robin search is a function or loop inside this module. It is not a separate block.

## Test plan
All scenarios use M=3, N=2, R=4.
- **Single request:** port 2 with A=5, B=3. Expect `req_ready`=4'b0100 for one cycle, `rsp_valid` two cycles later, `rsp_p`=15, `rsp_id`=2.
- **All ports at once:** all four valid with (1,1), (2,2), (3,3), (7,3); `rsp_ready`=1. Expect responses with ids 0,1,2,3 and products 1,4,9,21, each 3 cycles apart. `rr_ptr` then returns to 0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP. Expect `rsp_valid`=1 and `rsp_p`/`rsp_id` unchanged, no `req_ready` asserted. Release → IDLE next cycle.
- **Fairness:** ports 0 and 3 permanently valid, starting from `rr_ptr`=3. Expect grants alternating 3,0,3,0. Ports 1 and 2 are never granted.
- **Reset mid-operation:** `rst_n` low during MUL. Outputs go to 0 immediately. After release, `rsp_valid` stays 0 until a new grant. With all ports valid, port 0 is granted first.
- **Boundary operands:** A=0, B=3 → 0; A=7, B=0 → 0; A=7, B=3 → 21. Check the upper bits of `rsp_p` are correct and no truncation occurs.
